// File: rtl/img_pkg.sv
// Shared image-stream definitions: default raster geometry, field widths and
// the reader FSM state encoding.
package img_pkg;
   localparam int IMAGE_WIDTH_DEF  = 640;
   localparam int IMAGE_HEIGHT_DEF = 480;
   localparam int COL_W            = 10;
   localparam int ROW_W            = 10;
   localparam int PIX_W            = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_HBLANK = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;
endpackage

// File: rtl/raster_counter.sv
// Column/row raster position counter with end-of-line and end-of-frame flags;
// advances one pixel per enabled cycle, wrapping to (0,0) after the last pixel.
module raster_counter
   import img_pkg::*;
#(
   parameter int WIDTH  = IMAGE_WIDTH_DEF,
   parameter int HEIGHT = IMAGE_HEIGHT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row,
   output logic             end_of_line,
   output logic             end_of_frame
);
   logic [COL_W-1:0] col_reg;
   logic [ROW_W-1:0] row_reg;

   assign col          = col_reg;
   assign row          = row_reg;
   assign end_of_line  = (col_reg == COL_W'(WIDTH - 1));
   assign end_of_frame = end_of_line && (row_reg == ROW_W'(HEIGHT - 1));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (enable) begin
         if (end_of_line) begin
            col_reg <= '0;
            row_reg <= end_of_frame ? '0 : row_reg + 1'b1;
         end else begin
            col_reg <= col_reg + 1'b1;
         end
      end
   end
endmodule

// File: rtl/frame_stream_source.sv
// Reads one raster frame from a synchronous-read frame buffer on start and
// streams it out with column/row tags, optional line blanking and pause throttle.
module frame_stream_source
   import img_pkg::*;
#(
   parameter int IMAGE_WIDTH   = 640,
   parameter int IMAGE_HEIGHT  = 480,
   parameter int HBLANK_CYCLES = 4,
   parameter int ADDR_WIDTH    = 19
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  pause,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [PIX_W-1:0]      mem_rd_data,
   output logic [PIX_W-1:0]      pixel_out,
   output logic                  pixel_out_valid,
   output logic [COL_W-1:0]      col,
   output logic [ROW_W-1:0]      row,
   output logic                  busy,
   output logic                  frame_done
);
   localparam int HB_W    = (HBLANK_CYCLES > 1) ? $clog2(HBLANK_CYCLES) : 1;
   localparam int HB_LAST = (HBLANK_CYCLES > 0) ? HBLANK_CYCLES - 1 : 0;

   state_t                state_reg, state_next;
   logic [HB_W-1:0]       hb_cnt_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic                  valid_reg;
   logic [COL_W-1:0]      col_reg;
   logic [ROW_W-1:0]      row_reg;
   logic [PIX_W-1:0]      pix_hold_reg;

   logic                  accept, issue, blank_done;
   logic [COL_W-1:0]      issue_col;
   logic [ROW_W-1:0]      issue_row;
   logic                  eol, eof;

   assign accept     = (state_reg == ST_IDLE) && start;
   assign issue      = (state_reg == ST_ACTIVE) && !pause;
   assign blank_done = (hb_cnt_reg == HB_W'(HB_LAST));

   raster_counter #(
      .WIDTH  (IMAGE_WIDTH),
      .HEIGHT (IMAGE_HEIGHT)
   ) u_raster (
      .clk          (clk),
      .reset        (reset),
      .clear        (accept),
      .enable       (issue),
      .col          (issue_col),
      .row          (issue_row),
      .end_of_line  (eol),
      .end_of_frame (eof)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (start) state_next = ST_ACTIVE;
         ST_ACTIVE: begin
            if (issue && eol) begin
               if (eof)                    state_next = ST_DRAIN;
               else if (HBLANK_CYCLES > 0) state_next = ST_HBLANK;
               else                        state_next = ST_ACTIVE;
            end
         end
         ST_HBLANK: if (blank_done) state_next = ST_ACTIVE;
         ST_DRAIN:  state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Issue-side tags are delayed one stage so they line up with the RAM's read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         hb_cnt_reg   <= '0;
         addr_reg     <= '0;
         valid_reg    <= 1'b0;
         col_reg      <= '0;
         row_reg      <= '0;
         pix_hold_reg <= '0;
      end else begin
         state_reg  <= state_next;
         hb_cnt_reg <= (state_reg == ST_HBLANK && !blank_done) ? hb_cnt_reg + 1'b1 : '0;
         if (accept)     addr_reg <= '0;
         else if (issue) addr_reg <= addr_reg + 1'b1;
         valid_reg <= issue;
         if (issue) begin
            col_reg <= issue_col;
            row_reg <= issue_row;
         end
         if (valid_reg) pix_hold_reg <= mem_rd_data;
      end
   end

   assign mem_rd_en       = issue;
   assign mem_addr        = addr_reg;
   assign pixel_out       = valid_reg ? mem_rd_data : pix_hold_reg;
   assign pixel_out_valid = valid_reg;
   assign col             = col_reg;
   assign row             = row_reg;
   assign busy            = (state_reg != ST_IDLE);
   assign frame_done      = (state_reg == ST_DRAIN);
endmodule

// File: tb/tb_frame_stream_source.sv
// Randomized self-checking bench: two 4x3 readers (blanking 2 and 0) checked
// beat-by-beat against a closed-form raster timing model.
module tb_frame_stream_source;
   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic       clk = 1'b0;
   logic       rst_s   [2];
   logic       start_s [2];
   logic       pause_s [2];
   logic       rd_en_s [2];
   logic [18:0] addr_s [2];
   logic [7:0] pix_s   [2];
   logic       valid_s [2];
   logic [9:0] col_s   [2];
   logic [9:0] row_s   [2];
   logic       busy_s  [2];
   logic       done_s  [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int start_ref [2];
   int exp_idx   [2];
   int issued    [2];
   int pk_a      [2];
   int pl_a      [2];
   bit active    [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         logic [7:0] rdata;
         logic [7:0] ram [0:255];
         initial for (int a = 0; a < 256; a++) ram[a] = 8'(a);
         always @(posedge clk) if (rd_en_s[gi]) rdata <= ram[addr_s[gi][7:0]];

         frame_stream_source #(
            .IMAGE_WIDTH   (W),
            .IMAGE_HEIGHT  (H),
            .HBLANK_CYCLES ((gi == 0) ? 2 : 0),
            .ADDR_WIDTH    (19)
         ) dut (
            .clk             (clk),
            .reset           (rst_s[gi]),
            .start           (start_s[gi]),
            .pause           (pause_s[gi]),
            .mem_rd_en       (rd_en_s[gi]),
            .mem_addr        (addr_s[gi]),
            .mem_rd_data     (rdata),
            .pixel_out       (pix_s[gi]),
            .pixel_out_valid (valid_s[gi]),
            .col             (col_s[gi]),
            .row             (row_s[gi]),
            .busy            (busy_s[gi]),
            .frame_done      (done_s[gi])
         );
      end
   endgenerate

   function automatic int hb_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   // First cycle in which the pause window is driven (the issue cycle of beat pk).
   function automatic int pause_cycle(input int d);
      return start_ref[d] + 1 + pk_a[d] + (pk_a[d] / W) * hb_of(d);
   endfunction

   task automatic check_val(input string tag, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         pause_s[d] = active[d] && (pl_a[d] > 0) && (cyc >= pause_cycle(d))
                      && (cyc < pause_cycle(d) + pl_a[d]);
      end
   endtask

   task automatic start_frame(input int d, input int pk, input int pl);
      start_s[d]   = 1'b1;
      start_ref[d] = cyc;
      exp_idx[d]   = 0;
      issued[d]    = 0;
      pk_a[d]      = pk;
      pl_a[d]      = pl;
      active[d]    = 1'b1;
      tick();
      start_s[d] = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int budget = 300;
      while (active[d] && budget > 0) begin
         tick();
         budget--;
      end
      if (active[d]) begin
         check_val("frame_timeout", 0, 1);
         active[d] = 1'b0;
      end
   endtask

   task automatic check_all_zero(input int d);
      check_val("zero_rd_en", int'(rd_en_s[d]), 0);
      check_val("zero_addr",  int'(addr_s[d]),  0);
      check_val("zero_pixel", int'(pix_s[d]),   0);
      check_val("zero_valid", int'(valid_s[d]), 0);
      check_val("zero_col",   int'(col_s[d]),   0);
      check_val("zero_row",   int'(row_s[d]),   0);
      check_val("zero_busy",  int'(busy_s[d]),  0);
      check_val("zero_done",  int'(done_s[d]),  0);
   endtask

   // Beat k of a frame appears at start + 2 + k, plus blanking of completed rows,
   // plus the pause length once the paused beat has been passed.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (pause_s[d]) check_val("rd_during_pause", int'(rd_en_s[d]), 0);
         if (active[d]) begin
            check_val("busy", int'(busy_s[d]), (cyc > start_ref[d]) ? 1 : 0);
            if (rd_en_s[d]) begin
               check_val("addr", int'(addr_s[d]), issued[d]);
               issued[d]++;
            end
            if (valid_s[d] || done_s[d]) begin
               int k;
               int t;
               k = exp_idx[d];
               t = start_ref[d] + 2 + k + (k / W) * hb_of(d) + ((k >= pk_a[d]) ? pl_a[d] : 0);
               check_val("valid", int'(valid_s[d]), 1);
               check_val("pixel", int'(pix_s[d]), k % 256);
               check_val("col",   int'(col_s[d]), k % W);
               check_val("row",   int'(row_s[d]), k / W);
               check_val("beat_cycle", cyc, t);
               check_val("frame_done", int'(done_s[d]), (k == N - 1) ? 1 : 0);
               exp_idx[d]++;
               if (done_s[d]) begin
                  check_val("beat_count", exp_idx[d], N);
                  active[d] = 1'b0;
               end
            end
         end else begin
            check_val("idle_valid", int'(valid_s[d]), 0);
            check_val("idle_done",  int'(done_s[d]),  0);
            check_val("idle_busy",  int'(busy_s[d]),  0);
         end
      end
   end

   initial begin
      int t;
      for (int d = 0; d < 2; d++) begin
         rst_s[d] = 1'b1; start_s[d] = 1'b0; pause_s[d] = 1'b0;
         active[d] = 1'b0; pk_a[d] = 0; pl_a[d] = 0;
         start_ref[d] = 0; exp_idx[d] = 0; issued[d] = 0;
      end
      repeat (3) tick();
      for (int d = 0; d < 2; d++) check_all_zero(d);
      rst_s[0] = 1'b0; rst_s[1] = 1'b0;
      repeat (2) tick();

      // Blanked and back-to-back frames, then a pause at beat 5.
      start_frame(0, 0, 0); wait_done(0); tick();
      start_frame(1, 0, 0); wait_done(1); tick();
      start_frame(1, 5, 3); wait_done(1); tick();

      // start pulsed mid-frame and in the frame_done cycle: both ignored.
      start_frame(0, 0, 0);
      t = start_ref[0] + 2 + 7 + (7 / W) * hb_of(0);
      while (cyc < t) tick();
      start_s[0] = 1'b1; tick(); start_s[0] = 1'b0;
      t = start_ref[0] + N + (H - 1) * hb_of(0) + 1;
      while (cyc < t) tick();
      start_s[0] = 1'b1; tick(); start_s[0] = 1'b0;
      wait_done(0);
      repeat (2) tick();
      check_val("start_at_done_ignored", int'(busy_s[0]), 0);
      start_frame(0, 0, 0); wait_done(0); tick();

      // Reset while beat 6 is on the output.
      start_frame(0, 0, 0);
      t = start_ref[0] + 2 + 6 + (6 / W) * hb_of(0);
      while (cyc < t) tick();
      rst_s[0] = 1'b1;
      tick();
      active[0] = 1'b0;
      rst_s[0] = 1'b0;
      check_all_zero(0);
      repeat (3) tick();
      start_frame(0, 0, 0); wait_done(0); tick();

      for (int r = 0; r < 8; r++) begin
         int d;
         d = int'($urandom_range(0, 1));
         start_frame(d, int'($urandom_range(0, N - 1)), int'($urandom_range(0, 4)));
         wait_done(d);
         repeat (int'($urandom_range(1, 3))) tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
